rtc_read_sequencer: RTL

Parametrised read-address sequencer for the RTC register bank.
- On a start request, walks NUM_REGS consecutive register addresses from BASE_ADDR (default 0x21..0x26).
- Runs a req/ack handshake with the RTC bus controller for each address and returns each read byte tagged with its index.
- Sits between the display/time-keeping control FSM and the RTC bus interface.
- Replaces the fixed counter-to-address decode with an owned counter, handshake, continuous mode and error detection.

---
 rtl/rtc_seq_pkg.sv | 26 ++
 rtl/rtc_seq_timer.sv | 33 +++
 rtl/rtc_read_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rtc_seq_pkg.sv
// Shared types and constants for the RTC read-address sequencer.
package rtc_seq_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } rtc_seq_state_e;

  // First time-keeping register and number of registers in one time/date sweep.
  localparam logic [7:0]  RTC_BASE_ADDR     = 8'h21;
  localparam int unsigned RTC_NUM_TIME_REGS = 6;

  // Width of a register index: max(1, clog2(n)).
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) begin
      w = unsigned'($clog2(n));
    end
    return w;
  endfunction

endpackage

// File: rtl/rtc_seq_timer.sv
// Bus-acknowledge wait counter for the RTC read sequencer.
// Compiled only when RTC_SEQ_TIMEOUT_EN is defined; the default build has no timeout logic.
`ifdef RTC_SEQ_TIMEOUT_EN
module rtc_seq_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  // The count only needs to reach Limit-1: expired_o flags the cycle that would be the Limit-th.
  localparam int unsigned CntW = (Limit < 2) ? 1 : $clog2(Limit);
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q;

  // Count waiting cycles; hold at the limit so the counter can never wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High during the cycle that completes Limit waiting cycles.
  assign expired_o = (cnt_q == LastCnt);

endmodule
`endif

// File: rtl/rtc_read_sequencer.sv
// RTC read-address sequencer: on start, walks NUM_REGS register addresses from BASE_ADDR with a
// req/ack handshake per register and returns each read byte tagged with its index.
// Optional: define RTC_SEQ_TIMEOUT_EN to abort a sweep when bus_ack does not arrive within
// TIMEOUT_CYC request cycles (err pulse); otherwise the sequencer waits indefinitely.
module rtc_read_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RTC_BASE_ADDR),
  parameter int unsigned NUM_REGS    = RTC_NUM_TIME_REGS,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned IDX_W      = idx_width(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              cont_mode_i,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  rtc_seq_state_e    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

  logic last_idx;
  logic timeout_hit;

  assign last_idx = (idx_q == LastIdx);

`ifdef RTC_SEQ_TIMEOUT_EN
  logic wait_expired;
  logic err_q;

  // The counter is held clear outside ISSUE, so every ISSUE entry starts from zero.
  rtc_seq_timer #(
    .Limit(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (state_q != StIssue),
    .en_i     ((state_q == StIssue) && !bus_ack_i),
    .expired_o(wait_expired)
  );

  // An ack arriving in the limit cycle still completes normally.
  assign timeout_hit = (state_q == StIssue) && !bus_ack_i && wait_expired;

  // One-cycle err pulse following the aborting edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Next-state, index and read-capture logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (bus_ack_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus_rdata_i;
          rd_idx_d   = idx_q;
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StGap;
          end
        end else if (timeout_hit) begin
          // Abort the sweep; continuous mode deliberately does not restart after an error.
          idx_d   = '0;
          state_d = StIdle;
        end
      end

      // Guarantees a low bus_req cycle between consecutive requests.
      StGap: begin
        state_d = StIssue;
      end

      StDone: begin
        idx_d = '0;
        if (cont_mode_i) begin
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State, index and read-result registers; reset aborts any sweep on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Bus and status outputs decode directly from registered state, so they are glitch-free and
  // bus_addr stays stable for the whole request; the address wraps modulo 2^ADDR_W.
  assign bus_req_o  = (state_q == StIssue);
  assign bus_addr_o = bus_req_o ? (BASE_ADDR + ADDR_W'(idx_q)) : '0;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_idx_o   = rd_idx_q;

endmodule
